tone_decoder: RTL and testbench
===============================

Name: tone_decoder

Overview:
- Receive-side counterpart of the buzzer music player: measures the period of an incoming square-wave tone and decodes it back to a scale-note code.
- Also reports note start/end events and note length in periods.
- Sits between a pin or comparator input (or a loopback of the buzzer line) and the display/score logic, in the same single clock domain.

Parameters:
- TOL, 512: classification tolerance in clk cycles, applied as |period - REF_k| <= TOL.
- STABLE_CNT, 4: consecutive matching periods required to lock onto a note.
- SIL_TIMEOUT, 200000: clk cycles without a rising edge before the input is treated as silence.
- CW, 18: width of the period counter, which saturates at 2^CW-1.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous reset, active-high
- tone_in  in  1  asynchronous square-wave input
- note_code  out  3  0 = silence; 1..7 = M1, M2, M3, M5, M6, M7, H1
- active  out  1  high while a note is locked
- note_start  out  1  one-cycle pulse when a note locks
- note_end  out  1  one-cycle pulse when a locked note ends
- note_len  out  16  periods in the note just ended; valid with note_end, held until the next note_end

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, sync flops 0. rst has priority over every other event, including mid-lock; no note_end is emitted on reset.
- Input path: 2-FF synchronizer, then a registered rising-edge detector. Internal pulse `rise` marks one cycle per synchronized rising edge.
- Period counter:
  - Increments every cycle and saturates at 2^CW-1.
  - On `rise`, the count+1 is latched as `period` and the counter restarts at 0.
  - `period` therefore equals the cycles between consecutive edges. A generator using constant T produces period T+1.
- Classification (registered, 1 cycle after `rise`):
  - Class k applies if |period - REF_k| <= TOL; otherwise class = invalid.
  - References: REF = {95601, 85151, 75851, 63751, 56801, 50601, 47751}.
  - Tolerance windows do not overlap at default TOL. If they overlap, the lowest k wins.
- FSM (updates on the cycle after classification):
  - IDLE: first `rise` -> ACQ. The first edge only starts timing; no period is classified.
  - ACQ:
    - Each classified period updates a candidate and a stable count.
    - If the class matches the candidate, stable count +1; otherwise candidate = class and stable count = 1.
    - An invalid class forces stable count = 0.
    - When stable count reaches STABLE_CNT: go to LOCK, note_code = candidate, active = 1, note_start pulse, len count = STABLE_CNT.
  - LOCK:
    - A matching period increments len count, saturating at 65535.
    - A non-matching period (valid or invalid): note_end pulse, note_len = len count, note_code = 0, active = 0, go to ACQ with the candidate reseeded from this period.
  - Any state except IDLE: if the period counter reaches SIL_TIMEOUT with no `rise`, go to IDLE. If in LOCK, emit note_end with note_len = len count. note_code becomes 0.
- Simultaneous events:
  - `rise` on the same cycle the counter hits SIL_TIMEOUT: `rise` wins, no timeout.
  - note_end and note_start never assert in the same cycle; relocking needs STABLE_CNT more periods.
- Latency: note_start/note_end are asserted 4 clk cycles after the clk edge that first samples tone_in high on the deciding edge (2 sync + edge detect + classify/FSM).
- Duty cycle is ignored; only rising edges matter.

Decomposition:
- Shared package `music_pkg`:
  - note period constants M1..H1 (shared with the player);
  - REF_k = constant + 1 table;
  - 3-bit note code enum (SIL, M1, M2, M3, M5, M6, M7, H1);
  - FSM state typedef (IDLE, ACQ, LOCK).
- One sub-module, `edge_sync`: 2-FF synchronizer plus rising-edge pulse.
- Classifier and FSM stay in tone_decoder.

Test Plan:
- Reset: assert rst 3 cycles with tone_in toggling -> all outputs 0. Repeat rst mid-LOCK -> outputs 0 next cycle, no note_end.
- Lock: 8 periods of 95601 cycles, 50% duty -> note_start with note_code=1 at the 5th rising edge + 4 cycles; active=1.
- Note change: after lock on 95601, switch to 85151 -> note_end with note_len = periods played; after 4 periods of 85151, note_start with note_code=2.
- Silence: after lock on 56801 (code 5), hold tone_in low -> note_end SIL_TIMEOUT+4 cycles after the last edge; note_code=0; active=0.
- Tolerance boundary: periods of 63751+512 -> lock, code 4. Periods of 63751+513 -> no note_start ever. An out-of-table period of 70000 -> no note_start.
- Full melody loopback: the buzzer player's 60-note sequence drives tone_in -> note_code sequence matches the score. Each note's note_len equals the player's audible-on periods for that note: on-time / (T+1), where on-time is 7/8 of its num periods of T+1 cycles each.

Source files
------------

// File: rtl/music_pkg.sv
// Note tables and shared types for the buzzer player and the tone decoder.
// REF_k is the measured edge-to-edge period of a note whose generator constant is T_k.
package music_pkg;

  localparam int NOTE_NUM = 7;

  localparam int unsigned T_M1 = 95600;
  localparam int unsigned T_M2 = 85150;
  localparam int unsigned T_M3 = 75850;
  localparam int unsigned T_M5 = 63750;
  localparam int unsigned T_M6 = 56800;
  localparam int unsigned T_M7 = 50600;
  localparam int unsigned T_H1 = 47750;

  // Index 0 holds M1, index 6 holds H1.
  localparam logic [NOTE_NUM-1:0][31:0] REF_DEF = {
    32'(T_H1 + 1), 32'(T_M7 + 1), 32'(T_M6 + 1), 32'(T_M5 + 1),
    32'(T_M3 + 1), 32'(T_M2 + 1), 32'(T_M1 + 1)
  };

  typedef enum logic [2:0] {
    NOTE_SIL = 3'd0,
    NOTE_M1  = 3'd1,
    NOTE_M2  = 3'd2,
    NOTE_M3  = 3'd3,
    NOTE_M5  = 3'd4,
    NOTE_M6  = 3'd5,
    NOTE_M7  = 3'd6,
    NOTE_H1  = 3'd7
  } note_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } dec_state_e;

  function automatic logic within_tol(input logic [31:0] p, input logic [31:0] r,
                                      input logic [31:0] tol);
    return (p >= r) ? ((p - r) <= tol) : ((r - p) <= tol);
  endfunction

endpackage

// File: rtl/tone_decoder_edge_sync.sv
// Two-flop synchronizer for the tone pin followed by a registered rising-edge pulse.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic meta_q, sync_q, prev_q, rise_q;
  logic rise_d;

  always_comb begin
    rise_d = sync_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/tone_decoder.sv
// Measures the period of a square-wave tone, classifies it against the note table
// and reports locked notes with start/end pulses and note length in periods.
//
// state | meaning
// IDLE  | no timing reference yet; next edge only starts the period counter
// ACQ   | classifying periods, waiting for STABLE_CNT matching ones in a row
// LOCK  | note locked; counting matching periods until a mismatch or silence
module tone_decoder
  import music_pkg::*;
#(
  parameter int unsigned TOL         = 512,
  parameter int unsigned STABLE_CNT  = 4,
  parameter int unsigned SIL_TIMEOUT = 200000,
  parameter int unsigned CW          = 18,
  parameter logic [NOTE_NUM-1:0][31:0] REF = REF_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tone_in,
  output logic [2:0]  note_code,
  output logic        active,
  output logic        note_start,
  output logic        note_end,
  output logic [15:0] note_len
);

  localparam int SW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic rise;

  edge_sync u_edge_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (tone_in),
    .rise (rise)
  );

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] period;
  note_code_e    cls_q, cls_d;
  logic          cls_vld_q, cls_vld_d;
  logic          timeout;

  assign period  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
  assign timeout = (cnt_q == CW'(SIL_TIMEOUT)) && !rise;

  always_comb begin
    cnt_d     = rise ? '0 : period;
    cls_vld_d = rise;
    cls_d     = NOTE_SIL;
    // Descending scan so the lowest matching index wins when windows overlap.
    for (int k = NOTE_NUM - 1; k >= 0; k--) begin
      if (within_tol(32'(period), REF[k], 32'(TOL))) cls_d = note_code_e'(3'(k + 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      cls_q     <= NOTE_SIL;
      cls_vld_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      cls_q     <= cls_d;
      cls_vld_q <= cls_vld_d;
    end
  end

  dec_state_e    state_q, state_d;
  note_code_e    cand_q, cand_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [15:0]   len_q, len_d;
  note_code_e    note_code_q, note_code_d;
  logic          active_q, active_d;
  logic          start_q, start_d;
  logic          end_q, end_d;
  logic [15:0]   note_len_q, note_len_d;

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    stab_d      = stab_q;
    len_d       = len_q;
    note_code_d = note_code_q;
    active_d    = active_q;
    start_d     = 1'b0;
    end_d       = 1'b0;
    note_len_d  = note_len_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cls_vld_q) begin
          state_d = ST_ACQ;
          cand_d  = NOTE_SIL;
          stab_d  = '0;
        end
      end

      ST_ACQ: begin
        if (timeout) begin
          state_d = ST_IDLE;
          cand_d  = NOTE_SIL;
          stab_d  = '0;
        end else if (cls_vld_q) begin
          if (cls_q == NOTE_SIL) begin
            cand_d = NOTE_SIL;
            stab_d = '0;
          end else if (cls_q == cand_q) begin
            stab_d = stab_q + SW'(1);
          end else begin
            cand_d = cls_q;
            stab_d = SW'(1);
          end
          if (cls_q != NOTE_SIL && stab_d == SW'(STABLE_CNT)) begin
            state_d     = ST_LOCK;
            note_code_d = cls_q;
            active_d    = 1'b1;
            start_d     = 1'b1;
            len_d       = 16'(STABLE_CNT);
          end
        end
      end

      ST_LOCK: begin
        if (timeout) begin
          state_d     = ST_IDLE;
          end_d       = 1'b1;
          note_len_d  = len_q;
          note_code_d = NOTE_SIL;
          active_d    = 1'b0;
          cand_d      = NOTE_SIL;
          stab_d      = '0;
        end else if (cls_vld_q) begin
          if (cls_q == cand_q) begin
            len_d = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
          end else begin
            // The breaking period seeds the next acquisition; no relock here.
            state_d     = ST_ACQ;
            end_d       = 1'b1;
            note_len_d  = len_q;
            note_code_d = NOTE_SIL;
            active_d    = 1'b0;
            cand_d      = cls_q;
            stab_d      = (cls_q == NOTE_SIL) ? SW'(0) : SW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cand_q      <= NOTE_SIL;
      stab_q      <= '0;
      len_q       <= '0;
      note_code_q <= NOTE_SIL;
      active_q    <= 1'b0;
      start_q     <= 1'b0;
      end_q       <= 1'b0;
      note_len_q  <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      stab_q      <= stab_d;
      len_q       <= len_d;
      note_code_q <= note_code_d;
      active_q    <= active_d;
      start_q     <= start_d;
      end_q       <= end_d;
      note_len_q  <= note_len_d;
    end
  end

  assign note_code  = note_code_q;
  assign active     = active_q;
  assign note_start = start_q;
  assign note_end   = end_q;
  assign note_len   = note_len_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Bench for tone_decoder with a scaled note table: a run-length model of the
// tone predicts every output cycle by cycle, plus literal checks per scenario.
module tb_tone_decoder;

  localparam int TOL    = 2;
  localparam int STABLE = 4;
  localparam int SIL    = 300;
  localparam int CW     = 10;
  localparam int HIGH   = 40;

  int refs [7] = '{191, 170, 152, 128, 114, 101, 96};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tone_in = 1'b0;
  logic [2:0]  note_code;
  logic        active, note_start, note_end;
  logic [15:0] note_len;

  tone_decoder #(
    .TOL         (TOL),
    .STABLE_CNT  (STABLE),
    .SIL_TIMEOUT (SIL),
    .CW          (CW),
    .REF         ({32'd96, 32'd101, 32'd114, 32'd128, 32'd152, 32'd170, 32'd191})
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tone_in    (tone_in),
    .note_code  (note_code),
    .active     (active),
    .note_start (note_start),
    .note_end   (note_end),
    .note_len   (note_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  int n_print = 0;

  typedef struct {int t; bit start; int code; int len;} ev_t;
  ev_t evq[$];

  // Model: runs of consecutive periods in the same class.
  bit m_first = 1'b1;
  int m_last = 0;
  int run_cls = 0;
  int run_len = 0;
  bit m_locked = 1'b0;
  int exp_code = 0;
  bit exp_active = 1'b0;
  int exp_len = 0;

  int last_drv = -100000;
  int drv_edges[$];
  int mon_st_t[$], mon_st_c[$], mon_en_t[$], mon_en_l[$];

  function automatic int classify(int p);
    int c = 0;
    for (int k = 6; k >= 0; k--) begin
      if (((p > refs[k]) ? p - refs[k] : refs[k] - p) <= TOL) c = k + 1;
    end
    return c;
  endfunction

  function automatic void push_ev(int t, bit s, int code, int len);
    ev_t e;
    e.t = t; e.start = s; e.code = code; e.len = len;
    evq.push_back(e);
  endfunction

  function automatic void model_end(int t);
    if (m_locked) push_ev(t, 1'b0, 0, (run_len > 65535) ? 65535 : run_len);
    m_locked = 1'b0;
  endfunction

  function automatic void model_timeout();
    model_end(m_last + SIL + 4);
    run_len = 0;
    run_cls = 0;
    m_first = 1'b1;
  endfunction

  function automatic void model_edge(int t);
    int p, c;
    if (m_first) begin
      m_first = 1'b0;
      m_last = t;
      return;
    end
    p = t - m_last;
    m_last = t;
    c = classify(p);
    if (c == 0) begin
      model_end(t + 4);
      run_len = 0;
      run_cls = 0;
    end else if (c == run_cls && run_len > 0) begin
      run_len++;
      if (!m_locked && run_len == STABLE) begin
        m_locked = 1'b1;
        push_ev(t + 4, 1'b1, c, 0);
      end
    end else begin
      model_end(t + 4);
      run_cls = c;
      run_len = 1;
    end
  endfunction

  function automatic void model_reset();
    evq.delete();
    m_first = 1'b1; run_len = 0; run_cls = 0; m_locked = 1'b0;
    exp_code = 0; exp_active = 1'b0; exp_len = 0;
  endfunction

  always @(negedge clk) begin : cmp
    bit es, ee;
    es = 1'b0;
    ee = 1'b0;
    while (evq.size() > 0 && evq[0].t <= cyc) begin
      if (evq[0].start) begin
        es = 1'b1; exp_code = evq[0].code; exp_active = 1'b1;
      end else begin
        ee = 1'b1; exp_code = 0; exp_active = 1'b0; exp_len = evq[0].len;
      end
      void'(evq.pop_front());
    end
    n_chk++;
    if (note_code === 3'(exp_code) && active === exp_active && note_start === es &&
        note_end === ee && note_len === 16'(exp_len)) begin
      n_pass++;
    end else if (n_print < 20) begin
      n_print++;
      $display("FAIL cycle_model @%0d: got code=%0d act=%0d start=%0d end=%0d len=%0d, expected code=%0d act=%0d start=%0d end=%0d len=%0d",
               cyc, note_code, active, note_start, note_end, note_len,
               exp_code, exp_active, es, ee, exp_len);
    end
    if (note_start === 1'b1) begin mon_st_t.push_back(cyc); mon_st_c.push_back(int'(note_code)); end
    if (note_end === 1'b1) begin mon_en_t.push_back(cyc); mon_en_l.push_back(int'(note_len)); end
  end

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_mon();
    mon_st_t.delete(); mon_st_c.delete(); mon_en_t.delete(); mon_en_l.delete();
    drv_edges.delete();
  endtask

  // One drive slot; an edge driven here is first sampled at posedge cyc+1.
  task automatic step(bit v);
    @(negedge clk);
    #1;
    if (!rst && !m_first && (cyc + 1 - m_last) >= SIL + 2) model_timeout();
    if (v && !tone_in) begin
      last_drv = cyc + 1;
      drv_edges.push_back(cyc + 1);
      if (!rst) model_edge(cyc + 1);
    end
    tone_in = v;
  endtask

  task automatic play(int p, int n);
    for (int i = 0; i < n; i++) begin
      do step(1'b0); while (cyc + 2 < last_drv + p);
      repeat (HIGH) step(1'b1);
    end
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0);
  endtask

  task automatic pulse_reset();
    model_reset();
    rst = 1'b1;
    step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    rst = 1'b0;
  endtask

  int mel_p [8] = '{191, 153, 113, 96, 170, 128, 101, 151};
  int mel_c [8] = '{1, 3, 5, 7, 2, 4, 6, 3};
  int mel_e [8] = '{7, 6, 9, 8, 6, 7, 10, 6};

  initial begin
    step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    rst = 1'b0;
    chk("reset_outputs", int'({note_code, active, note_start, note_end, note_len}), 0);

    clear_mon();
    play(191, 9);
    idle(8);
    chk("lock_start_count", mon_st_t.size(), 1);
    chk("lock_start_time", qat(mon_st_t, 0), qat(drv_edges, 4) + 4);
    chk("lock_code", qat(mon_st_c, 0), 1);
    chk("lock_active", int'(active), 1);

    clear_mon();
    play(170, 5);
    idle(8);
    chk("change_end_count", mon_en_t.size(), 1);
    chk("change_end_len", qat(mon_en_l, 0), 8);
    chk("change_end_time", qat(mon_en_t, 0), qat(drv_edges, 0) + 4);
    chk("change_start_code", qat(mon_st_c, 0), 2);
    chk("change_start_time", qat(mon_st_t, 0), qat(drv_edges, 3) + 4);

    clear_mon();
    play(114, 6);
    idle(SIL + 20);
    chk("sil_end_count", mon_en_t.size(), 2);
    chk("sil_end_len", qat(mon_en_l, 1), 6);
    chk("sil_end_time", qat(mon_en_t, 1), qat(drv_edges, 5) + SIL + 4);
    chk("sil_code", int'(note_code), 0);
    chk("sil_active", int'(active), 0);

    clear_mon();
    play(130, 6);
    idle(8);
    chk("tol_edge_lock_code", qat(mon_st_c, 0), 4);
    idle(SIL + 20);
    clear_mon();
    play(131, 8);
    idle(SIL + 20);
    chk("tol_over_nostart", mon_st_t.size(), 0);
    chk("tol_over_noend", mon_en_t.size(), 0);
    clear_mon();
    play(140, 8);
    idle(SIL + 20);
    chk("offtable_nostart", mon_st_t.size(), 0);

    clear_mon();
    play(128, 6);
    play(SIL + 1, 1);
    idle(8);
    chk("risewins_end_time", qat(mon_en_t, 0), qat(drv_edges, 6) + 4);
    chk("risewins_end_len", qat(mon_en_l, 0), 5);
    clear_mon();
    play(128, 6);
    play(SIL + 2, 1);
    idle(8);
    chk("timeout_end_time", qat(mon_en_t, 0), qat(drv_edges, 5) + SIL + 4);
    chk("timeout_end_len", qat(mon_en_l, 0), 6);

    clear_mon();
    play(191, 7);
    chk("prereset_active", int'(active), 1);
    pulse_reset();
    idle(10);
    chk("midlock_reset_noend", mon_en_t.size(), 0);
    chk("midlock_reset_outputs", int'({note_code, active, note_start, note_end, note_len}), 0);

    for (int i = 0; i < 8; i++) begin
      clear_mon();
      play(mel_p[i], mel_e[i]);
      idle(SIL + 20);
      chk($sformatf("mel%0d_starts", i), mon_st_t.size(), 1);
      chk($sformatf("mel%0d_code", i), qat(mon_st_c, 0), mel_c[i]);
      chk($sformatf("mel%0d_ends", i), mon_en_t.size(), 1);
      chk($sformatf("mel%0d_len", i), qat(mon_en_l, 0), mel_e[i] - 1);
    end

    chk("model_queue_drained", evq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
